// File: rtl/pf_ddr4_wrlvl_pkg.sv
// Shared types and constants for the DDR4 DQSW write-leveling sequencer.
package pf_ddr4_wrlvl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        STROBE,
        SETTLE,
        SAMPLE,
        MOVE,
        MOVE_WAIT,
        DONE,
        ERR
    } wrlvl_state_t;

    localparam logic [1:0] DQS_PATTERN      = 2'b10;
    localparam logic [1:0] OE_ON            = 2'b11;
    localparam int         MOVE_WAIT_CYCLES = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pf_ddr4_dqsw_wrlvl_ctrl.sv
// Write-leveling sweep for one DQSW lane: steps the DQS delay until DQ feedback shows 0->1.
// Optional DQSW_MAJORITY_VOTE_EN: three captures per tap, decided by 2-of-3 majority.
module pf_ddr4_dqsw_wrlvl_ctrl
    import pf_ddr4_wrlvl_pkg::*;
#(
    parameter logic [7:0] TAP_MAX       = 8'd127,
    parameter int         SETTLE_CYCLES = 16
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       TRAIN_START,
    output logic       TRAIN_BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] TAP_COUNT,
    output logic [1:0] TX_DATA_0,
    output logic [1:0] OE_DATA_0,
    output logic       ODT_EN_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    input  logic [1:0] RX_DATA_0
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WW = 1;

    wrlvl_state_t    state;
    logic [SW-1:0]   settle_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            prev_sample;
    logic            sample_bit;
    logic            unused_rx;

    assign ODT_EN_0  = 1'b0;
    assign unused_rx = RX_DATA_0[1];

`ifdef DQSW_MAJORITY_VOTE_EN
    logic [1:0] vote_cnt;
    logic [1:0] votes;
    assign sample_bit = majority3(votes[0], votes[1], RX_DATA_0[0]);
`else
    assign sample_bit = RX_DATA_0[0];
`endif

    // Outputs are registered: each transition sets the values the next state presents.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                  <= IDLE;
            settle_cnt             <= '0;
            wait_cnt               <= '0;
            prev_sample            <= 1'b1;
            TRAIN_BUSY             <= 1'b0;
            TRAIN_DONE             <= 1'b0;
            TRAIN_ERR              <= 1'b0;
            TAP_COUNT              <= 8'd0;
            TX_DATA_0              <= 2'b00;
            OE_DATA_0              <= 2'b00;
            DELAY_LINE_LOAD_0      <= 1'b0;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
`ifdef DQSW_MAJORITY_VOTE_EN
            vote_cnt               <= 2'd0;
            votes                  <= 2'b00;
`endif
        end else begin
            TRAIN_DONE             <= 1'b0;
            TX_DATA_0              <= 2'b00;
            OE_DATA_0              <= 2'b00;
            DELAY_LINE_LOAD_0      <= 1'b0;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (TRAIN_START) begin
                        state             <= LOAD;
                        TAP_COUNT         <= 8'd0;
                        prev_sample       <= 1'b1;
                        TRAIN_ERR         <= 1'b0;
                        TRAIN_BUSY        <= 1'b1;
                        DELAY_LINE_LOAD_0 <= 1'b1;
`ifdef DQSW_MAJORITY_VOTE_EN
                        vote_cnt          <= 2'd0;
`endif
                    end
                end
                LOAD: begin
                    state     <= STROBE;
                    TX_DATA_0 <= DQS_PATTERN;
                    OE_DATA_0 <= OE_ON;
                end
                STROBE: begin
                    state      <= SETTLE;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
`ifdef DQSW_MAJORITY_VOTE_EN
                    if (vote_cnt != 2'd2) begin
                        votes[vote_cnt[0]] <= RX_DATA_0[0];
                        vote_cnt           <= vote_cnt + 2'd1;
                        state              <= STROBE;
                        TX_DATA_0          <= DQS_PATTERN;
                        OE_DATA_0          <= OE_ON;
                    end else
`endif
                    // A 1 seen before any 0 is not an edge; prev_sample starts at 1 for that reason.
                    begin
                        if (!prev_sample && sample_bit) begin
                            state      <= DONE;
                            TRAIN_DONE <= 1'b1;
                        end else if (TAP_COUNT == TAP_MAX || DELAY_LINE_OUT_OF_RANGE_0) begin
                            state     <= ERR;
                            TRAIN_ERR <= 1'b1;
                        end else begin
                            prev_sample            <= sample_bit;
                            state                  <= MOVE;
                            DELAY_LINE_MOVE_0      <= 1'b1;
                            DELAY_LINE_DIRECTION_0 <= 1'b1;
                        end
                    end
                end
                MOVE: begin
                    state    <= MOVE_WAIT;
                    wait_cnt <= WW'(MOVE_WAIT_CYCLES - 1);
`ifdef DQSW_MAJORITY_VOTE_EN
                    vote_cnt <= 2'd0;
`endif
                end
                MOVE_WAIT: begin
                    if (wait_cnt == '0) begin
                        TAP_COUNT <= TAP_COUNT + 8'd1;
                        state     <= STROBE;
                        TX_DATA_0 <= DQS_PATTERN;
                        OE_DATA_0 <= OE_ON;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    TRAIN_BUSY <= 1'b0;
                end
                ERR: begin
                    state      <= IDLE;
                    TRAIN_BUSY <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    TRAIN_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pf_ddr4_dqsw_wrlvl_ctrl.sv
// Scoreboard bench for pf_ddr4_dqsw_wrlvl_ctrl with a behavioural IOD/DRAM feedback model.
module tb_pf_ddr4_dqsw_wrlvl_ctrl;

    localparam int         S    = 4;
    localparam logic [7:0] TMAX = 8'd10;

    typedef struct {
        bit         is_err;
        logic [7:0] tap;
        int         moves;
        int         lat;
    } exp_t;

    logic       FAB_CLK;
    logic       ARST_N;
    logic       TRAIN_START;
    logic       TRAIN_BUSY;
    logic       TRAIN_DONE;
    logic       TRAIN_ERR;
    logic [7:0] TAP_COUNT;
    logic [1:0] TX_DATA_0;
    logic [1:0] OE_DATA_0;
    logic       ODT_EN_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;
    logic [1:0] RX_DATA_0;

    pf_ddr4_dqsw_wrlvl_ctrl #(.TAP_MAX(TMAX), .SETTLE_CYCLES(S)) dut (
        .FAB_CLK                   (FAB_CLK),
        .ARST_N                    (ARST_N),
        .TRAIN_START               (TRAIN_START),
        .TRAIN_BUSY                (TRAIN_BUSY),
        .TRAIN_DONE                (TRAIN_DONE),
        .TRAIN_ERR                 (TRAIN_ERR),
        .TAP_COUNT                 (TAP_COUNT),
        .TX_DATA_0                 (TX_DATA_0),
        .OE_DATA_0                 (OE_DATA_0),
        .ODT_EN_0                  (ODT_EN_0),
        .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
        .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
        .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
        .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
        .RX_DATA_0                 (RX_DATA_0)
    );

    initial FAB_CLK = 1'b0;
    always #5 FAB_CLK = ~FAB_CLK;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           n_moves = 0;
    int           n_loads = 0;
    int           last_move_cyc = -1000;
    int           sweeps_seen = 0;
    bit           done_prev = 1'b0;
    exp_t         sb_q[$];

    int           iod_tap = 0;
    int           sidx = 0;
    logic [127:0] fb_vec = '0;
    int           oor_tap = -1;
    bit           vote_test = 1'b0;

    // DRAM feedback as a function of the modelled IOD tap and capture index within the tap.
    always_comb begin
        RX_DATA_0 = 2'b00;
        if (vote_test && iod_tap == 4)
            RX_DATA_0[0] = (sidx == 1);
        else if (vote_test && iod_tap == 5)
            RX_DATA_0[0] = (sidx != 1);
        else
            RX_DATA_0[0] = fb_vec[iod_tap];
        DELAY_LINE_OUT_OF_RANGE_0 = (oor_tap >= 0) && (iod_tap >= oor_tap);
    end

    function automatic int lat(input int n);
`ifdef DQSW_MAJORITY_VOTE_EN
        return 2 + n * (3 * (S + 2) + 3) + 3 * (S + 2);
`else
        return 2 + n * (S + 5) + S + 2;
`endif
    endfunction

    task automatic check_output(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: tracks the IOD model, protocol rules, and pops the scoreboard at sweep end.
    always @(negedge FAB_CLK) begin
        cyc++;
        if (ARST_N) begin
            if (TRAIN_START && !TRAIN_BUSY) begin
                start_cyc = cyc;
                n_moves   = 0;
                n_loads   = 0;
            end
            if (DELAY_LINE_LOAD_0) begin
                n_loads++;
                iod_tap = 0;
                sidx    = 0;
                check_output("err_cleared_on_load", int'(TRAIN_ERR), 0);
                check_output("busy_on_load", int'(TRAIN_BUSY), 1);
            end
            if (DELAY_LINE_MOVE_0) begin
                check_output("move_direction", int'(DELAY_LINE_DIRECTION_0), 1);
                check_output("move_gap_ok", int'((cyc - last_move_cyc) >= 3), 1);
                last_move_cyc = cyc;
                n_moves++;
                if (DELAY_LINE_DIRECTION_0) iod_tap++;
                sidx = 0;
            end
            if (OE_DATA_0 == 2'b11) begin
                check_output("strobe_pattern", int'(TX_DATA_0), 2);
                sidx++;
            end
            if (done_prev) check_output("done_pulse_width", int'(TRAIN_DONE), 0);
            done_prev = TRAIN_DONE;
            if (TRAIN_BUSY && (TRAIN_DONE || TRAIN_ERR)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sweep_end: tap=%0d with no expectation", TAP_COUNT);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_output("result_err", int'(TRAIN_ERR), int'(e.is_err));
                    check_output("result_done", int'(TRAIN_DONE), int'(!e.is_err));
                    check_output("tap_count", int'(TAP_COUNT), int'(e.tap));
                    check_output("move_pulses", n_moves, e.moves);
                    check_output("load_pulses", n_loads, 1);
                    check_output("latency", cyc - start_cyc, e.lat);
                end
                sweeps_seen++;
            end
        end
    end

    task automatic apply_stimulus(input logic [127:0] vec, input int oor, input bit vote,
                                  input bit is_err, input int tap);
        exp_t e;
        int   target;
        fb_vec    = vec;
        oor_tap   = oor;
        vote_test = vote;
        e.is_err  = is_err;
        e.tap     = 8'(tap);
        e.moves   = tap;
        e.lat     = lat(tap);
        sb_q.push_back(e);
        target = sweeps_seen + 1;
        @(posedge FAB_CLK);
        #1 TRAIN_START = 1'b1;
        @(posedge FAB_CLK);
        #1 TRAIN_START = 1'b0;
        for (int i = 0; i < 1000 && sweeps_seen < target; i++) @(posedge FAB_CLK);
        if (sweeps_seen < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL sweep_timeout: sweeps=%0d expected %0d", sweeps_seen, target);
            sb_q.delete();
        end
        repeat (3) @(posedge FAB_CLK);
    endtask

    function automatic int outputs_packed();
        return int'({TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT, TX_DATA_0, OE_DATA_0,
                     ODT_EN_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0});
    endfunction

    logic [127:0] vec_edge5;
    logic [127:0] vec_late7;

    initial begin
        bit found;
        vec_edge5 = ~((128'd1 << 5) - 128'd1);
        vec_late7 = ~((128'd1 << 7) - 128'd1) | 128'h7;
        ARST_N      = 1'b0;
        TRAIN_START = 1'b0;
        repeat (3) @(posedge FAB_CLK);
        #1 check_output("reset_outputs_zero", outputs_packed(), 0);
        ARST_N = 1'b1;
        repeat (2) @(posedge FAB_CLK);

        apply_stimulus(vec_edge5, -1, 1'b0, 1'b0, 5);
        apply_stimulus(vec_late7, -1, 1'b0, 1'b0, 7);
        apply_stimulus('0, -1, 1'b0, 1'b1, int'(TMAX));
        check_output("err_level_held", int'(TRAIN_ERR), 1);
        apply_stimulus('0, 3, 1'b0, 1'b1, 3);
        check_output("oor_err_level", int'(TRAIN_ERR), 1);

        // Abort a sweep during SETTLE at tap 2.
        fb_vec  = vec_edge5;
        oor_tap = -1;
        @(posedge FAB_CLK);
        #1 TRAIN_START = 1'b1;
        @(posedge FAB_CLK);
        #1 TRAIN_START = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge FAB_CLK);
            if (TAP_COUNT == 8'd2 && OE_DATA_0 == 2'b11) found = 1'b1;
        end
        check_output("reached_tap2_strobe", int'(found), 1);
        @(posedge FAB_CLK);
        @(posedge FAB_CLK);
        #1 ARST_N = 1'b0;
        #1 check_output("midsweep_reset_zero", outputs_packed(), 0);
        repeat (2) @(posedge FAB_CLK);
        #1 ARST_N = 1'b1;
        repeat (2) @(posedge FAB_CLK);
        apply_stimulus(vec_edge5, -1, 1'b0, 1'b0, 5);

`ifdef DQSW_MAJORITY_VOTE_EN
        apply_stimulus(~((128'd1 << 6) - 128'd1), -1, 1'b1, 1'b0, 5);
`endif

        check_output("scoreboard_empty", sb_q.size(), 0);
        check_output("odt_constant", int'(ODT_EN_0), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
